present_dec_round_core: RTL and testbench

- Iterative 64-bit PRESENT block-decryption round engine.
- Sits directly upstream of the 64-bit decryption substitution layer in the decrypt path, and here carries that nibble-wise inverse S-box step internally.
- Per round: adds the round key, applies the inverse bit permutation, then the inverse S-box layer.
- Round keys come from an external key store. A valid/ready handshake wraps a multi-cycle operation.

---
 rtl/present_dec_round_core.sv | 104 ++++++++++
 tb/tb_present_dec_round_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_dec_round_core.sv
`timescale 1ns/1ps
// Iterative PRESENT-64 decryption round engine: per round adds the key, inverse
// permutes, then applies the inverse S-box; final key whitening follows the last round.
module present_dec_round_core #(
    parameter int unsigned ROUNDS = 31,
    parameter int unsigned IDXW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     data_in,
    output logic [IDXW-1:0] rk_idx,
    input  logic [63:0]     rk,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     data_out
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t          state, state_next;
    logic [63:0]     blk, blk_next;
    logic [IDXW-1:0] rnd, rnd_next;
    logic [IDXW-1:0] rk_idx_next;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // out[i] = in[P(i)] with P(i) = 16*i mod 63, bit 63 fixed
    function automatic logic [63:0] inv_round(input logic [63:0] x);
        logic [63:0] p;
        logic [63:0] y;
        for (int unsigned i = 0; i < 63; i++) p[6'(i)] = x[6'((16 * i) % 63)];
        p[63] = x[63];
        for (int unsigned k = 0; k < 16; k++) y[6'(4 * k) +: 4] = inv_sbox(p[6'(4 * k) +: 4]);
        return y;
    endfunction

    always_comb begin
        state_next = state;
        blk_next   = blk;
        rnd_next   = rnd;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    blk_next   = data_in;
                    rnd_next   = IDXW'(ROUNDS);
                    state_next = ROUND;
                end
            end
            ROUND: begin
                blk_next = inv_round(blk ^ rk);
                rnd_next = rnd - 1'b1;
                if (rnd == IDXW'(1)) state_next = FINAL;
            end
            FINAL: begin
                blk_next   = blk ^ rk;
                state_next = DONE;
            end
            default: begin
                if (out_ready) state_next = IDLE;
            end
        endcase
    end

    // rk_idx is registered from next-state so it never glitches. With the default
    // sizing the first round's index (ROUNDS+1 = 32) wraps to 0 in IDXW bits.
    always_comb begin
        rk_idx_next = '0;
        case (state_next)
            ROUND:   rk_idx_next = rnd_next + 1'b1;
            FINAL:   rk_idx_next = IDXW'(1);
            default: rk_idx_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            blk    <= '0;
            rnd    <= '0;
            rk_idx <= '0;
        end else begin
            state  <= state_next;
            blk    <= blk_next;
            rnd    <= rnd_next;
            rk_idx <= rk_idx_next;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign data_out  = blk;

endmodule

// File: tb/tb_present_dec_round_core.sv
`timescale 1ns/1ps
// Scoreboarded bench for present_dec_round_core: a forward PRESENT encryption model
// generates ciphertexts, a monitor checks plaintext and latency whenever output is taken.
module tb_present_dec_round_core;

    localparam int RA = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_data_in, a_data_out, a_rk;
    logic [4:0]  a_rk_idx;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_data_in, b_data_out, b_rk;
    logic [4:0]  b_rk_idx;

    logic [63:0] keys [32];

    always_comb a_rk = keys[a_rk_idx];
    assign b_rk = '0;

    present_dec_round_core #(.ROUNDS(31), .IDXW(5)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_in(a_data_in), .rk_idx(a_rk_idx), .rk(a_rk), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .data_out(a_data_out)
    );

    present_dec_round_core #(.ROUNDS(1), .IDXW(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_in(b_data_in), .rk_idx(b_rk_idx), .rk(b_rk), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_data_out)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    int acc_q[$];
    int acc_log[$];
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inverse(input logic [3:0] y);
        for (int v = 0; v < 16; v++) if (sbox(4'(v)) == y) return 4'(v);
        return 4'h0;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'((i == 63) ? 63 : (16 * i) % 63)] = x[6'(i)];
        return y;
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt, input int rounds);
        logic [63:0] s = pt;
        for (int r = 1; r <= rounds; r++) begin
            s = s ^ keys[5'(r % 32)];
            for (int k = 0; k < 16; k++) s[6'(4 * k) +: 4] = sbox(s[6'(4 * k) +: 4]);
            s = p_layer(s);
        end
        return s ^ keys[5'((rounds + 1) % 32)];
    endfunction

    // P has order 3, so applying it twice undoes it
    function automatic logic [63:0] decrypt(input logic [63:0] ct, input int rounds);
        logic [63:0] s = ct ^ keys[5'((rounds + 1) % 32)];
        for (int r = rounds; r >= 1; r--) begin
            s = p_layer(p_layer(s));
            for (int k = 0; k < 16; k++) s[6'(4 * k) +: 4] = sbox_inverse(s[6'(4 * k) +: 4]);
            s = s ^ keys[5'(r % 32)];
        end
        return s;
    endfunction

    task automatic load_present80_key(input logic [79:0] key);
        logic [79:0] k = key;
        for (int r = 1; r <= 32; r++) begin
            keys[5'(r % 32)] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
    endtask

    task automatic random_keys();
        for (int i = 0; i < 32; i++) keys[i] = {$urandom, $urandom};
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (a_in_valid && a_in_ready) begin
                acc_q.push_back(cyc + 1);
                acc_log.push_back(cyc + 1);
            end
            if (a_out_valid && !prev_valid) begin
                if (acc_q.size() == 0) check("orphan_out_valid", 64'(a_out_valid), 64'd0);
                else check("latency", 64'(cyc - acc_q.pop_front()), 64'(RA + 1));
            end
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 64'(a_out_valid), 64'd0);
                else check("data_out", a_data_out, exp_q.pop_front());
            end
            prev_valid = a_out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [63:0] ct, input logic [63:0] pt);
        int n = 0;
        a_data_in  = ct;
        a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) check("accept_timeout", 64'(a_in_ready), 64'd1);
        else exp_q.push_back(pt);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_b(input logic [63:0] din, input logic [63:0] req, input string name);
        int n = 0;
        b_data_in  = din;
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_out_valid && n < 20) begin @(negedge clk); n++; end
        check({name, "_valid"}, 64'(b_out_valid), 64'd1);
        check(name, b_data_out, req);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [63:0] pt, ct, pt2, ct2;
        int n;
        a_in_valid = 0; a_out_ready = 1; a_data_in = '0;
        b_in_valid = 0; b_out_ready = 1; b_data_in = '0;
        for (int i = 0; i < 32; i++) keys[i] = '0;

        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(a_out_valid), 64'd0);
        check("reset_in_ready", 64'(a_in_ready), 64'd1);
        check("reset_data_out", a_data_out, 64'd0);
        check("reset_rk_idx", 64'(a_rk_idx), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single round, zero keys
        run_b(64'h0, 64'h5555555555555555, "single_round_0");
        run_b(64'h1, 64'h555555555555555E, "single_round_1");
        run_b(64'h2, 64'h55555555555555E5, "single_round_2");

        // zero vector with rk_idx sequence 32(=0 in 5 bits),31..1, then 0
        send(64'h0, decrypt(64'h0, RA));
        a_in_valid = 0;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            check("rk_idx_seq", 64'(a_rk_idx), 64'((32 - k) % 32));
        end
        drain();

        // known answer, PRESENT-80 all-zero key
        load_present80_key(80'h0);
        send(64'h5579C1387B228445, 64'h0);
        a_in_valid = 0;
        drain();

        // random keys and blocks
        for (int t = 0; t < 6; t++) begin
            random_keys();
            pt = {$urandom, $urandom};
            ct = encrypt(pt, RA);
            send(ct, pt);
            a_in_valid = 0;
            drain();
        end

        // consumer stall and ignored in_valid during ROUND
        random_keys();
        pt = {$urandom, $urandom};
        ct = encrypt(pt, RA);
        a_out_ready = 0;
        send(ct, pt);
        a_in_valid = 0;
        repeat (5) @(posedge clk);
        #1 a_in_valid = 1; a_data_in = {$urandom, $urandom};
        @(negedge clk);
        check("in_ready_busy", 64'(a_in_ready), 64'd0);
        @(posedge clk); #1 a_in_valid = 0;
        n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
        for (int s = 0; s < 10; s++) begin
            check("stall_out_valid", 64'(a_out_valid), 64'd1);
            check("stall_data_out", a_data_out, pt);
            @(negedge clk);
        end
        @(posedge clk); #1 a_out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("post_handshake_out_valid", 64'(a_out_valid), 64'd0);
        check("post_handshake_in_ready", 64'(a_in_ready), 64'd1);
        drain();

        // asynchronous reset in the middle of round 10
        random_keys();
        pt = {$urandom, $urandom};
        send(encrypt(pt, RA), pt);
        a_in_valid = 0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_out_valid", 64'(a_out_valid), 64'd0);
        check("midreset_data_out", a_data_out, 64'd0);
        check("midreset_in_ready", 64'(a_in_ready), 64'd1);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        pt = {$urandom, $urandom};
        send(encrypt(pt, RA), pt);
        a_in_valid = 0;
        drain();

        // back-to-back with in_valid held high
        random_keys();
        pt  = {$urandom, $urandom};
        ct  = encrypt(pt, RA);
        pt2 = {$urandom, $urandom};
        ct2 = encrypt(pt2, RA);
        send(ct, pt);
        send(ct2, pt2);
        a_in_valid = 0;
        drain();
        if (acc_log.size() >= 2)
            check("b2b_gap", 64'(acc_log[acc_log.size() - 1] - acc_log[acc_log.size() - 2]), 64'(RA + 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
